cnna_mac_pipe_signed: RTL and testbench
=======================================

// Module: cnna_mac_pipe_signed
// PURPOSE
//  Parametrised, pipelined signed multiply-accumulate unit for the CNN datapath.
//  Streams (a,b) operand pairs under a valid/ready handshake. Products of a group
//  (delimited by first/last) are summed into a wide accumulator. One shifted,
//  narrowed result is emitted per group. Sits between the line-buffer/weight
//  fetch and the requantise/write-back stage.
// PARAMETERS
//  A_WIDTH     24  signed operand a width
//  B_WIDTH     16  signed operand b width
//  ACC_WIDTH   48  accumulator width; must be >= A_WIDTH+B_WIDTH
//  P_WIDTH     32  output width; must be <= ACC_WIDTH-OUT_SHIFT
//  MUL_STAGES  2   product pipeline registers; must be >= 1
//  OUT_SHIFT   0   arithmetic right shift applied to the accumulator on output
//  CNT_WIDTH   16  width of the per-group beat counter
// PORTS
//  ap_clk      in   1          clock, all logic on rising edge
//  ap_rst      in   1          synchronous, active-high reset
//  in_valid    in   1          operand beat valid
//  in_ready    out  1          beat accepted when in_valid && in_ready
//  in_a        in   A_WIDTH    signed operand a
//  in_b        in   B_WIDTH    signed operand b
//  in_first    in   1          beat starts a new group
//  in_last     in   1          beat ends the group; result emitted
//  out_valid   out  1          result valid
//  out_ready   in   1          result consumed when out_valid && out_ready
//  out_data    out  P_WIDTH    signed group result
//  out_count   out  CNT_WIDTH  beats in the group; saturates at all-ones
//  out_sat     out  1          result was clamped (CNNA_MAC_SAT_EN only, else 0)
//  proto_err   out  1          sticky protocol error flag
// BEHAVIOUR
//  - Reset: all pipe valids=0, acc=0, group_open=0. Outputs out_valid=0,
//    out_data=0, out_count=0, out_sat=0, proto_err=0. in_ready=1 the cycle after.
//  - Global enable en = !out_valid || out_ready. in_ready = en.
//    When en=0 the whole pipe, accumulator and outputs freeze.
//  - Product: sext(a)*sext(b), exact A_WIDTH+B_WIDTH bits. It passes MUL_STAGES
//    registers, each carrying valid/first/last, then enters the accumulate stage.
//  - Accumulate stage (product valid && en):
//      first or !group_open : acc<=sext(p), cnt<=1
//      else                 : acc<=acc+sext(p) (wraps mod 2^ACC_WIDTH), cnt<=cnt+1 sat
//    proto_err<=1 if !first && !group_open.
//    group_open <= !last.
//    first arriving while group_open silently restarts the group; no error.
//  - On a last beat: out_valid<=1, out_data<=narrow(acc_next>>>OUT_SHIFT),
//    out_count<=cnt_next.
//  - Otherwise, when out_valid && out_ready: out_valid<=0. out_data is held.
//  - Latency: a last beat accepted at edge t gives out_valid=1 after edge
//    t+MUL_STAGES+1 (no stall). Throughput is 1 beat/cycle.
//  - first&&last on one beat: result is that single product, count=1.
//  - out_data, out_count and out_sat are stable while out_valid && !out_ready.
//  - Reset mid-group discards all in-flight beats and the partial sum.
// CONFIGURATION
//  CNNA_MAC_SAT_EN defined:
//    narrow() clamps to [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1].
//    out_sat=1 when the clamp is applied, registered with out_data.
//  CNNA_MAC_SAT_EN undefined:
//    narrow() keeps the low P_WIDTH bits (two's-complement wrap).
//    out_sat is tied 0 and no compare logic is built.
// TESTING (defaults, MUL_STAGES=2, out_ready=1 unless stated)
//  1 first&last, a=-3,b=7 at edge t -> out_valid after edge t+3,
//    out_data=-21, out_count=1, proto_err=0.
//  2 4-beat group, a=1000,b=1000 each -> one result 4000000, count=4;
//    back-to-back groups at full rate give no bubbles.
//  3 out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, out_data held,
//    pipe frozen; after release all results arrive in order, none lost.
//  4 two beats a=-2^23,b=-2^15 (sum 2^39):
//    SAT_EN -> out_data=0x7FFFFFFF, out_sat=1;
//    no SAT_EN -> out_data=0x00000000.
//  5 first beat omitted after reset, a=2,b=5 last=1 -> proto_err=1 (sticky),
//    out_data=10, count=1.
//  6 ap_rst pulsed after beat 2 of a 4-beat group -> all outputs 0, next group
//    a=1,b=1 x3 -> out_data=3, count=3.
//  7 OUT_SHIFT=4 rebuild, a=-1,b=1 single beat -> out_data=-1 (arithmetic shift).

Source files
------------

// File: rtl/cnna_mac_pipe_signed_if.sv
// ---------------------------------------------------------------------------
// cnna_mac_pipe_signed_if
// Operand-stream and result-stream bundle for the signed MAC pipe.
//   in_valid/in_ready    operand beat handshake (in_a, in_b, in_first, in_last)
//   out_valid/out_ready  group result handshake (out_data, out_count, out_sat)
//   proto_err            sticky protocol error flag from the MAC
// Modports:
//   master  upstream / testbench side: drives operands and out_ready
//   slave   MAC side: drives in_ready, results and proto_err
// ---------------------------------------------------------------------------
interface cnna_mac_pipe_signed_if #(
    parameter int A_WIDTH   = 24,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 32,
    parameter int CNT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [A_WIDTH-1:0]   in_a;
    logic signed [B_WIDTH-1:0]   in_b;
    logic                        in_first;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [P_WIDTH-1:0]   out_data;
    logic        [CNT_WIDTH-1:0] out_count;
    logic                        out_sat;
    logic                        proto_err;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_sat, proto_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_sat, proto_err
    );
endinterface

// File: rtl/cnna_mac_pipe_signed.sv
// ---------------------------------------------------------------------------
// cnna_mac_pipe_signed
// Pipelined signed multiply-accumulate for the CNN datapath. Operand pairs
// stream in; products of a group (in_first .. in_last) are summed into an
// ACC_WIDTH accumulator and one shifted, narrowed result is emitted per group.
//
// Ports:
//   ap_clk   clock, rising edge
//   ap_rst   synchronous active-high reset
//   bus      cnna_mac_pipe_signed_if.slave (operand stream, result stream,
//            sticky proto_err)
//
// Optional feature macro: CNNA_MAC_SAT_EN
//   defined   -> result is clamped to the signed P_WIDTH range, out_sat flags it
//   undefined -> result keeps the low P_WIDTH bits, out_sat is tied 0
//
// Pipeline: operand register -> MUL_STAGES product registers -> accumulate
// stage, whose output registers hold the group result. A single global enable
// (no result pending, or result being consumed) advances every stage at once.
// ---------------------------------------------------------------------------
module cnna_mac_pipe_signed #(
    parameter int A_WIDTH    = 24,
    parameter int B_WIDTH    = 16,
    parameter int ACC_WIDTH  = 48,
    parameter int P_WIDTH    = 32,
    parameter int MUL_STAGES = 2,
    parameter int OUT_SHIFT  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input logic                    ap_clk,
    input logic                    ap_rst,
    cnna_mac_pipe_signed_if.slave  bus
);
    localparam int PW = A_WIDTH + B_WIDTH;

    logic en;
    assign en          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    // ---------------- operand register ----------------
    logic signed [A_WIDTH-1:0] a_reg;
    logic signed [B_WIDTH-1:0] b_reg;
    logic                      in_v_reg, in_f_reg, in_l_reg;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            in_v_reg <= 1'b0;
            in_f_reg <= 1'b0;
            in_l_reg <= 1'b0;
        end else if (en) begin
            a_reg    <= bus.in_a;
            b_reg    <= bus.in_b;
            in_v_reg <= bus.in_valid;
            in_f_reg <= bus.in_first;
            in_l_reg <= bus.in_last;
        end
    end

    // Both operands are signed, so they are sign-extended to PW before the
    // multiply and the exact product fits.
    logic signed [PW-1:0] prod_comb;
    assign prod_comb = a_reg * b_reg;

    // ---------------- product pipeline ----------------
    genvar gi;
    generate
        for (gi = 0; gi < MUL_STAGES; gi++) begin : g_stage
            logic signed [PW-1:0] prod_src;
            logic                 v_src, f_src, l_src;
            logic signed [PW-1:0] prod_reg;
            logic                 v_reg, f_reg, l_reg;

            if (gi == 0) begin : g_src
                assign prod_src = prod_comb;
                assign v_src    = in_v_reg;
                assign f_src    = in_f_reg;
                assign l_src    = in_l_reg;
            end else begin : g_src
                assign prod_src = g_stage[gi-1].prod_reg;
                assign v_src    = g_stage[gi-1].v_reg;
                assign f_src    = g_stage[gi-1].f_reg;
                assign l_src    = g_stage[gi-1].l_reg;
            end

            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    prod_reg <= '0;
                    v_reg    <= 1'b0;
                    f_reg    <= 1'b0;
                    l_reg    <= 1'b0;
                end else if (en) begin
                    prod_reg <= prod_src;
                    v_reg    <= v_src;
                    f_reg    <= f_src;
                    l_reg    <= l_src;
                end
            end
        end
    endgenerate

    logic signed [PW-1:0] p_last;
    logic                 pv_last, pf_last, pl_last;
    assign p_last  = g_stage[MUL_STAGES-1].prod_reg;
    assign pv_last = g_stage[MUL_STAGES-1].v_reg;
    assign pf_last = g_stage[MUL_STAGES-1].f_reg;
    assign pl_last = g_stage[MUL_STAGES-1].l_reg;

    // ---------------- accumulate stage ----------------
    logic signed [ACC_WIDTH-1:0] acc_reg, acc_next, p_ext;
    logic        [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                        open_reg, proto_err_reg, restart;

    assign p_ext   = ACC_WIDTH'(p_last);
    // A beat without an open group is treated as a group start, so a missing
    // in_first still yields a sensible result (and raises proto_err).
    assign restart = pf_last || !open_reg;

    always_comb begin
        acc_next = acc_reg + p_ext;
        cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
        if (restart) begin
            acc_next = p_ext;
            cnt_next = CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            open_reg      <= 1'b0;
            proto_err_reg <= 1'b0;
        end else if (en && pv_last) begin
            acc_reg  <= acc_next;
            cnt_reg  <= cnt_next;
            open_reg <= !pl_last;
            if (!pf_last && !open_reg)
                proto_err_reg <= 1'b1;
        end
    end

    // ---------------- output narrowing ----------------
    logic signed [P_WIDTH-1:0] data_next;
    logic                      sat_next;

`ifdef CNNA_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        (ACC_WIDTH'(1) << (P_WIDTH-1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_WIDTH-1:0] shifted;
    assign shifted = acc_next >>> OUT_SHIFT;

    always_comb begin
        data_next = P_WIDTH'(shifted);
        sat_next  = 1'b0;
        if (shifted > SAT_MAX) begin
            data_next = P_WIDTH'(SAT_MAX);
            sat_next  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            data_next = P_WIDTH'(SAT_MIN);
            sat_next  = 1'b1;
        end
    end
`else
    assign data_next = P_WIDTH'(acc_next >>> OUT_SHIFT);
    assign sat_next  = 1'b0;
`endif

    // ---------------- result registers ----------------
    logic                      out_valid_reg, out_sat_reg;
    logic signed [P_WIDTH-1:0] out_data_reg;
    logic [CNT_WIDTH-1:0]      out_count_reg;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
            out_sat_reg   <= 1'b0;
        end else if (en) begin
            if (pv_last && pl_last) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= data_next;
                out_count_reg <= cnt_next;
                out_sat_reg   <= sat_next;
            end else if (out_valid_reg) begin
                // en with a pending result means it is being consumed now
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_count = out_count_reg;
`ifdef CNNA_MAC_SAT_EN
    assign bus.out_sat   = out_sat_reg;
`else
    assign bus.out_sat   = 1'b0;
`endif
    assign bus.proto_err = proto_err_reg;
endmodule

// File: tb/tb_cnna_mac_pipe_signed.sv
// ---------------------------------------------------------------------------
// tb_cnna_mac_pipe_signed
// Directed bench for cnna_mac_pipe_signed: one default instance and one
// OUT_SHIFT=4 instance. Results are collected on each accepted output
// handshake and compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_cnna_mac_pipe_signed;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    cnna_mac_pipe_signed_if #(.A_WIDTH(24), .B_WIDTH(16), .P_WIDTH(32), .CNT_WIDTH(16)) bus ();
    cnna_mac_pipe_signed_if #(.A_WIDTH(24), .B_WIDTH(16), .P_WIDTH(32), .CNT_WIDTH(16)) bus7 ();

    cnna_mac_pipe_signed dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    cnna_mac_pipe_signed #(.OUT_SHIFT(4)) dut7 (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus7)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] d;
        logic [15:0] c;
        logic        s;
    } res_t;
    res_t res_q[$];

    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (!ap_rst && bus.out_valid && bus.out_ready)
            res_q.push_back('{d: bus.out_data, c: bus.out_count, s: bus.out_sat});
    end

`ifdef CNNA_MAC_SAT_EN
    localparam logic [31:0] T4_DATA = 32'h7FFF_FFFF;
    localparam logic        T4_SAT  = 1'b1;
`else
    localparam logic [31:0] T4_DATA = 32'h0000_0000;
    localparam logic        T4_SAT  = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int a, input int b, input bit f, input bit l);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a[23:0];
        bus.in_b     = b[15:0];
        bus.in_first = f;
        bus.in_last  = l;
        while (!bus.in_ready && guard < 200) begin
            @(posedge ap_clk); #1;
            guard++;
        end
        chk("send_accept", 32'(bus.in_ready), 32'd1);
        @(posedge ap_clk); #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_d, input int exp_c, input logic exp_s);
        int guard = 0;
        res_t r;
        while (res_q.size() == 0 && guard < 100) begin
            @(posedge ap_clk); #1;
            guard++;
        end
        chk({tag, "_present"}, 32'(res_q.size() > 0), 32'd1);
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk({tag, "_data"}, r.d, exp_d);
            chk({tag, "_count"}, 32'(r.c), exp_c);
            chk({tag, "_sat"}, 32'(r.s), 32'(exp_s));
            $display("txn %s: data=%0d count=%0d sat=%0d", tag, $signed(r.d), r.c, r.s);
        end
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        repeat (2) begin
            @(posedge ap_clk); #1;
        end
        ap_rst = 1'b0;
    endtask

    task automatic send7(input string tag, input int a, input int exp_d);
        bus7.in_valid = 1'b1;
        bus7.in_a     = a[23:0];
        bus7.in_b     = 16'sd1;
        bus7.in_first = 1'b1;
        bus7.in_last  = 1'b1;
        @(posedge ap_clk); #1;
        bus7.in_valid = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk({tag, "_valid"}, 32'(bus7.out_valid), 32'd1);
        chk({tag, "_data"}, bus7.out_data, exp_d);
        $display("txn %s: data=%0d", tag, $signed(bus7.out_data));
    endtask

    initial begin
        int c0;
        idle();
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        bus7.in_valid = 1'b0;
        bus7.in_a     = '0;
        bus7.in_b     = '0;
        bus7.in_first = 1'b0;
        bus7.in_last  = 1'b0;
        bus7.out_ready = 1'b1;
        do_reset();

        // reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  bus.out_data, 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_out_sat",   32'(bus.out_sat), 32'd0);
        chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);

        // 1: single-beat group, latency MUL_STAGES+1 edges
        send(-3, 7, 1'b1, 1'b1);
        idle();
        chk("t1_valid_e0", 32'(bus.out_valid), 32'd0);
        @(posedge ap_clk); #1;
        chk("t1_valid_e1", 32'(bus.out_valid), 32'd0);
        @(posedge ap_clk); #1;
        chk("t1_valid_e2", 32'(bus.out_valid), 32'd0);
        @(posedge ap_clk); #1;
        chk("t1_valid_e3", 32'(bus.out_valid), 32'd1);
        chk("t1_data",     bus.out_data, -21);
        chk("t1_count",    32'(bus.out_count), 32'd1);
        chk("t1_proto",    32'(bus.proto_err), 32'd0);
        wait_result("t1", -21, 1, 1'b0);

        // 2: two back-to-back 4-beat groups at full rate
        c0 = cyc;
        for (int i = 0; i < 4; i++) send(1000, 1000, i == 0, i == 3);
        for (int i = 0; i < 4; i++) send(-5, 3, i == 0, i == 3);
        idle();
        chk("t2_no_bubble", 32'(cyc - c0), 32'd8);
        wait_result("t2a", 4000000, 4, 1'b0);
        wait_result("t2b", -60, 4, 1'b0);

        // 3: output stall freezes the pipe, nothing lost
        bus.out_ready = 1'b0;
        send(3, 4, 1'b1, 1'b1);
        send(5, 6, 1'b1, 1'b0);
        send(7, 8, 1'b0, 1'b1);
        idle();
        begin
            int guard = 0;
            while (!bus.out_valid && guard < 20) begin
                @(posedge ap_clk); #1;
                guard++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("t3_stall_ready", 32'(bus.in_ready), 32'd0);
            chk("t3_stall_data",  bus.out_data, 32'd12);
            @(posedge ap_clk); #1;
        end
        chk("t3_stall_queue", 32'(res_q.size()), 32'd0);
        bus.out_ready = 1'b1;
        wait_result("t3a", 12, 1, 1'b0);
        wait_result("t3b", 86, 2, 1'b0);

        // 4: sum exceeds the output range
        send(-8388608, -32768, 1'b1, 1'b0);
        send(-8388608, -32768, 1'b0, 1'b1);
        idle();
        wait_result("t4", T4_DATA, 2, T4_SAT);

        // 5: missing first after reset raises sticky proto_err
        do_reset();
        chk("t5_proto_pre", 32'(bus.proto_err), 32'd0);
        send(2, 5, 1'b0, 1'b1);
        idle();
        wait_result("t5", 10, 1, 1'b0);
        chk("t5_proto_set", 32'(bus.proto_err), 32'd1);
        send(1, 1, 1'b1, 1'b1);
        idle();
        wait_result("t5b", 1, 1, 1'b0);
        chk("t5_proto_sticky", 32'(bus.proto_err), 32'd1);

        // 6: reset mid-group discards the partial sum
        send(1, 1, 1'b1, 1'b0);
        send(1, 1, 1'b0, 1'b0);
        idle();
        do_reset();
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_data",  bus.out_data, 32'd0);
        chk("t6_count", 32'(bus.out_count), 32'd0);
        chk("t6_sat",   32'(bus.out_sat), 32'd0);
        chk("t6_proto", 32'(bus.proto_err), 32'd0);
        repeat (5) @(posedge ap_clk);
        #1;
        chk("t6_no_output", 32'(res_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) send(1, 1, i == 0, i == 2);
        idle();
        wait_result("t6", 3, 3, 1'b0);
        chk("t6_proto_after", 32'(bus.proto_err), 32'd0);

        // 7: OUT_SHIFT=4 instance, arithmetic shift
        send7("t7_m1", -1, -1);
        send7("t7_p100", 100, 6);
        send7("t7_m100", -100, -7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
